// File: rtl/fp_change_pkg.sv
// rtl/fp_change_pkg.sv - shared types and constants for the fp_change arbiter
package fp_change_pkg;

  localparam int FP_W            = 32;
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant starting at a pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  // Walk the request vector from the pointer upward, wrapping, and take the first hit
  always_comb begin
    logic w_found;
    int   w_j;
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = (int'(i_ptr) + k) % N_REQ;
      if (!w_found && i_req[w_j]) begin
        w_found    = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx      = IDX_W'(w_j);
      end
    end
  end

endmodule

// File: rtl/fp_change_arb.sv
// rtl/fp_change_arb.sv - round-robin sharing of one int-to-float converter
module fp_change_arb
  import fp_change_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int IDX_W   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rstnn,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [FP_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]       rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [FP_W-1:0]       cvt_int,
  output logic                  cvt_req,
  input  logic [FP_W-1:0]       cvt_fp,
  input  logic                  cvt_ack
);

  localparam int CNT_W = $clog2(TIMEOUT);

  fsm_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [FP_W-1:0]    r_cvt_int;
  logic               r_cvt_req;
  logic [N_REQ-1:0]   r_rsp_valid;
  logic [FP_W-1:0]    r_rsp_data;
  logic               r_rsp_err;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic [N_REQ-1:0]   w_owner_onehot;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_owner_onehot = N_REQ'(1) << r_owner;

  // Grants are only offered while idle; otherwise the in-flight request owns the converter
  assign req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign busy      = (r_state != ST_IDLE);
  assign cvt_int   = r_cvt_int;
  assign cvt_req   = r_cvt_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  // Sequencer: accept, hold the converter request until ack or watchdog, then respond
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_cvt_int   <= '0;
      r_cvt_req   <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_owner   <= w_idx;
            r_cvt_int <= req_data[FP_W*w_idx +: FP_W];
            r_ptr     <= (w_idx == IDX_W'(N_REQ-1)) ? '0 : w_idx + 1'b1;
            r_cvt_req <= 1'b1;
            r_cnt     <= '0;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_cnt <= r_cnt + 1'b1;
          // Ack wins over the watchdog when both land on the same edge
          if (cvt_ack) begin
            r_cvt_req <= 1'b0;
            r_state   <= ST_CAPTURE;
          end else if (r_cnt == CNT_W'(TIMEOUT-1)) begin
            r_cvt_req   <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_valid <= w_owner_onehot;
            r_state     <= ST_RESP;
          end
        end
        ST_CAPTURE: begin
          r_rsp_data  <= cvt_fp;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= w_owner_onehot;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          // rsp_data is left holding the last result for late observers
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_cvt_req   <= 1'b0;
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_change_arb.sv
// tb/tb_fp_change_arb.sv - randomized and directed bench for fp_change_arb
module tb_fp_change_arb;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rstnn;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_data;
  logic            rsp_err;
  logic            busy;
  logic [31:0]     cvt_int;
  logic            cvt_req;
  logic [31:0]     cvt_fp;
  logic            cvt_ack;

  fp_change_arb #(.N_REQ(N), .TIMEOUT(TMO), .IDX_W(2)) dut (
    .clk       (clk),
    .rstnn     (rstnn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .cvt_int   (cvt_int),
    .cvt_req   (cvt_req),
    .cvt_fp    (cvt_fp),
    .cvt_ack   (cvt_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Unsigned int to IEEE single, truncating the mantissa
  function automatic logic [31:0] fconv(input logic [31:0] x);
    int p;
    logic [31:0] m;
    logic [7:0]  e;
    if (x == 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 32; b++) if (x[b]) p = b;
    m = (p >= 23) ? (x >> (p - 23)) : (x << (23 - p));
    e = 8'(127 + p);
    return {1'b0, e, m[22:0]};
  endfunction

  // Converter stub: ack three edges into a request, clear ack on the next request-high edge
  logic no_ack = 1'b0;
  int   stub_cnt = 0;
  initial begin cvt_ack = 1'b0; cvt_fp = 32'h0; end
  always @(posedge clk) begin
    if (!cvt_req) begin
      stub_cnt = 0;
      cvt_ack <= 1'b0;
    end else if (cvt_ack) begin
      cvt_ack <= 1'b0;
    end else if (stub_cnt == 2) begin
      if (!no_ack) begin
        cvt_ack <= 1'b1;
        cvt_fp  <= fconv(cvt_int);
      end
    end else begin
      stub_cnt++;
    end
  end

  // Transaction-level reference: rr pointer, one owner, known cycle offsets after accept
  logic        run_chk = 1'b0;
  logic        m_active = 1'b0;
  int          m_k = 0, m_end = 0, m_reqlast = 0, m_owner = 0, m_ptr = 0;
  logic        m_tmo = 1'b0;
  logic [31:0] m_data = 0, m_exp = 0;
  logic [31:0] exp_val [N];
  logic [N-1:0] acc_mask = '0;
  int          log_owner[$];
  logic [31:0] log_data[$];
  logic        log_err[$];

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int g;
    logic [N-1:0] er;
    if (!rstnn) begin
      m_active = 1'b0;
      m_ptr    = 0;
    end else if (run_chk) begin
      if (m_active) begin
        m_k++;
        if (m_k == m_end) m_active = 1'b0;
      end
      if (!m_active) begin
        g  = pick(req_valid, m_ptr);
        er = (g >= 0) ? N'(1) << g : '0;
        chk("idle_ready", 32'(req_ready), 32'(er));
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp", 32'(rsp_valid), 0);
        chk("idle_cvt_req", 32'(cvt_req), 0);
        if (g >= 0) begin
          m_active  = 1'b1;
          m_k       = 0;
          m_owner   = g;
          m_data    = req_data[32*g +: 32];
          m_tmo     = no_ack;
          m_end     = no_ack ? TMO + 2 : 7;
          m_reqlast = no_ack ? TMO : 4;
          m_exp     = no_ack ? 32'h0 : exp_val[g];
          m_ptr     = (g + 1) % N;
          acc_mask  = acc_mask | er;
        end
      end else begin
        chk("busy_ready", 32'(req_ready), 0);
        chk("busy", 32'(busy), 1);
        chk("cvt_req", 32'(cvt_req), 32'(m_k <= m_reqlast));
        chk("cvt_int", cvt_int, m_data);
        er = (m_k == m_end - 1) ? N'(1) << m_owner : '0;
        chk("rsp_valid", 32'(rsp_valid), 32'(er));
        if (m_k == m_end - 1) begin
          chk("rsp_data", rsp_data, m_exp);
          chk("rsp_err", 32'(rsp_err), 32'(m_tmo));
          log_owner.push_back(m_owner);
          log_data.push_back(rsp_data);
          log_err.push_back(rsp_err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc_mask;
    acc_mask  = '0;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [31:0] e);
    req_data[32*i +: 32] = d;
    exp_val[i]           = e;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((req_valid != 0 || m_active) && c < 400) begin
      tick();
      c++;
    end
    if (c >= 400) chk("wait_idle_bound", 32'(c), 0);
  endtask

  task automatic expect_log(input int idx, input int owner, input logic [31:0] d, input logic err);
    if (log_owner.size() <= idx) begin
      chk("log_len", 32'(log_owner.size()), 32'(idx + 1));
    end else begin
      chk("log_owner", 32'(log_owner[idx]), 32'(owner));
      chk("log_data", log_data[idx], d);
      chk("log_err", 32'(log_err[idx]), 32'(err));
    end
  endtask

  task automatic clear_log();
    log_owner.delete();
    log_data.delete();
    log_err.delete();
  endtask

  logic [31:0] vals [4];
  logic [31:0] fps  [4];

  initial begin
    int c;
    logic [31:0] d;
    vals[0] = 32'd5;        fps[0] = 32'h40A00000;
    vals[1] = 32'd0;        fps[1] = 32'h00000000;
    vals[2] = 32'h80000000; fps[2] = 32'h4F000000;
    vals[3] = 32'hFFFFFFFF; fps[3] = 32'h4F7FFFFF;
    for (int i = 0; i < N; i++) exp_val[i] = 32'h0;
    rstnn     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cvt_req", 32'(cvt_req), 0);
    chk("rst_cvt_int", cvt_int, 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    rstnn   = 1'b1;
    run_chk = 1'b1;
    tick();

    // Single request
    clear_log();
    set_req(0, 32'd1, 32'h3F800000);
    wait_idle();
    expect_log(0, 0, 32'h3F800000, 1'b0);

    // Boundary operands on requester 2
    for (int v = 0; v < 4; v++) begin
      clear_log();
      set_req(2, vals[v], fps[v]);
      wait_idle();
      expect_log(0, 2, fps[v], 1'b0);
    end

    // Contention: pointer sits at 3 after requester 2, so align it by serving 3 first
    set_req(3, 32'd9, fconv(32'd9));
    wait_idle();
    clear_log();
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = 32'(i + 1);
    exp_val[0] = 32'h3F800000; exp_val[1] = 32'h40000000;
    exp_val[2] = 32'h40400000; exp_val[3] = 32'h40800000;
    req_valid = 4'b1111;
    wait_idle();
    expect_log(0, 0, 32'h3F800000, 1'b0);
    expect_log(1, 1, 32'h40000000, 1'b0);
    expect_log(2, 2, 32'h40400000, 1'b0);
    expect_log(3, 3, 32'h40800000, 1'b0);
    clear_log();
    req_valid = 4'b1001;
    wait_idle();
    expect_log(0, 0, 32'h3F800000, 1'b0);
    expect_log(1, 3, 32'h40800000, 1'b0);

    // Watchdog, then a normal conversion afterwards
    clear_log();
    no_ack = 1'b1;
    set_req(1, 32'd7, 32'hDEADBEEF);
    wait_idle();
    no_ack = 1'b0;
    expect_log(0, 1, 32'h0, 1'b1);
    clear_log();
    set_req(1, 32'd7, 32'h40E00000);
    wait_idle();
    expect_log(0, 1, 32'h40E00000, 1'b0);

    // Asynchronous reset in the middle of ISSUE
    clear_log();
    set_req(2, 32'd3, 32'h40400000);
    c = 0;
    while (!(m_active && m_k == 2) && c < 50) begin tick(); c++; end
    if (c >= 50) chk("reset_sync_bound", 32'(c), 0);
    #2;
    rstnn = 1'b0;
    #1;
    chk("arst_cvt_req", 32'(cvt_req), 0);
    chk("arst_rsp_valid", 32'(rsp_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    tick();
    tick();
    rstnn = 1'b1;
    repeat (8) tick();
    chk("arst_no_rsp", 32'(log_owner.size()), 0);
    set_req(1, 32'd2, 32'h40000000);
    set_req(3, 32'd4, 32'h40800000);
    wait_idle();
    expect_log(0, 1, 32'h40000000, 1'b0);
    expect_log(1, 3, 32'h40800000, 1'b0);

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 3))
            0: d = 32'h0;
            1: d = 32'($urandom_range(1, 255));
            default: d = $urandom;
          endcase
          set_req(i, d, fconv(d));
        end
      end
      tick();
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
